// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial pattern detector controller.
package seq_detect_pkg;

  localparam int unsigned DEF_PAT_W = 5;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: history shift register, fill tracking and comparator.
// hit is combinational and flags that the bit being accepted now completes the pattern.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             din_valid,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  history_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic              shift;

  assign shift = enable && din_valid;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    history_next = {history[PAT_W-2:0], din};
    fill_next    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hit          = shift && (fill_next == FILL_FULL) && (history_next == pattern);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= history_next;
      // Non-overlapping mode forces a full refill so no bit is reused.
      fill    <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time controller: config handshake, arm/stop/clear FSM, match counter and sticky irq
// around a single serial pattern matcher.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_threshold,
  input  logic             start,
  input  logic             stop,
  input  logic             din_valid,
  input  logic             din,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             irq,
  input  logic             irq_clr
);

  state_t           state;
  state_t           state_next;
  logic [PAT_W-1:0] pattern_q;
  logic             overlap_q;
  logic [CNT_W-1:0] threshold_q;
  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] count_inc;
  logic             start_ok;
  logic             stop_ok;
  logic             clr_ok;
  logic             hit;
  logic             count_hit;
  logic             reached;

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .enable   (state == ARMED),
    .din_valid(din_valid),
    .din      (din),
    .pattern  (pattern_q),
    .overlap  (overlap_q),
    .hit      (hit)
  );

  assign start_ok  = (state == IDLE) && start;
  assign stop_ok   = (state == ARMED) && stop;
  assign clr_ok    = (state == DONE) && irq_clr;
  // stop wins over a same-cycle hit.
  assign count_hit = hit && !stop_ok;
  assign count_inc = (match_count == '1) ? match_count : match_count + CNT_W'(1);
  assign thr_eff   = (threshold_q == '0) ? CNT_W'(1) : threshold_q;
  assign reached   = count_hit && (count_inc >= thr_eff);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = ARMED;
      ARMED: begin
        if (stop_ok)      state_next = IDLE;
        else if (reached) state_next = DONE;
      end
      DONE:    if (clr_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state == ARMED);
    irq       = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q   <= '0;
      overlap_q   <= 1'b0;
      threshold_q <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      if ((state == IDLE) && cfg_valid) begin
        pattern_q   <= cfg_pattern;
        overlap_q   <= cfg_overlap;
        threshold_q <= cfg_threshold;
      end
      match <= count_hit;
      if (start_ok)       match_count <= '0;
      else if (count_hit) match_count <= count_inc;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench: stimulus pushes expected match events into a scoreboard queue,
// a negedge monitor pops and compares whenever the DUT pulses match.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_threshold = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             irq_clr = 1'b0;
  logic             cfg_ready, match, busy, irq;
  logic [CNT_W-1:0] match_count;

  logic [1:0] thr2;
  logic       cfg_ready2, match2, busy2, irq2;
  logic [1:0] match_count2;
  assign thr2 = cfg_threshold[1:0];

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_threshold(cfg_threshold),
    .start(start), .stop(stop), .din_valid(din_valid), .din(din), .match(match),
    .match_count(match_count), .busy(busy), .irq(irq), .irq_clr(irq_clr)
  );

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_threshold(thr2),
    .start(start), .stop(stop), .din_valid(din_valid), .din(din), .match(match2),
    .match_count(match_count2), .busy(busy2), .irq(irq2), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    int   cnt;
    logic irq;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   exp_count = 0;
  int   thr_eff = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && match) begin
      if (sb.size() == 0) begin
        check("unexpected_match", match, 0);
      end else begin
        e = sb.pop_front();
        check("match_cycle", cyc, e.cyc);
        check("count_at_match", match_count, e.cnt);
        check("irq_at_match", irq, e.irq);
      end
    end
  end

  task automatic apply(input logic cv, input logic st, input logic sp,
                       input logic ic, input logic dv, input logic d);
    @(negedge clk);
    cfg_valid = cv; start = st; stop = sp; irq_clr = ic; din_valid = dv; din = d;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg_start(input logic [PAT_W-1:0] pat, input logic ovl, input int thr);
    @(negedge clk);
    cfg_pattern = pat; cfg_overlap = ovl; cfg_threshold = CNT_W'(thr);
    cfg_valid = 1; start = 1; stop = 0; irq_clr = 0; din_valid = 0; din = 0;
    exp_count = 0;
    thr_eff = (thr == 0) ? 1 : thr;
  endtask

  // bits[n-1] is sent first; hits marks the bit positions that complete a match.
  task automatic send(input logic [31:0] bits, input int n, input logic [31:0] hits, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      apply(0, 0, 0, 0, 1, bits[i]);
      if (hits[i]) begin
        exp_count++;
        sb.push_back('{cyc: cyc + 1, cnt: exp_count, irq: (exp_count == thr_eff)});
      end
      if (gap) apply(0, 0, 0, 0, 0, ~bits[i]);
    end
  endtask

  initial begin
    #12;
    check("rst_match", match, 0);
    check("rst_count", match_count, 0);
    check("rst_irq", irq, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk) reset = 1'b1;

    // 1: overlapping, threshold 3, config poke while armed is ignored
    cfg_start(5'b10001, 1, 3);
    @(negedge clk);
    cfg_valid = 1; start = 0; cfg_pattern = 5'b11111;
    check("t1_cfg_ready_armed", cfg_ready, 0);
    send(9'b100010001, 9, 9'b000010001, 0);
    idle();
    check("t1_count", match_count, 2);
    check("t1_irq", irq, 0);
    check("t1_busy", busy, 1);
    apply(0, 0, 1, 0, 0, 0);
    idle();
    check("t1_stop_busy", busy, 0);
    check("t1_stop_cfg_ready", cfg_ready, 1);
    check("t1_count_kept", match_count, 2);

    // 2: non-overlapping
    cfg_start(5'b10001, 0, 3);
    send(9'b100010001, 9, 9'b000010000, 0);
    idle();
    check("t2_count", match_count, 1);
    apply(0, 0, 1, 0, 0, 0);

    // 3: threshold 2 reaches DONE, din ignored, irq_clr
    cfg_start(5'b10001, 1, 2);
    send(9'b100010001, 9, 9'b000010001, 0);
    idle();
    check("t3_irq", irq, 1);
    check("t3_busy", busy, 0);
    check("t3_cfg_ready", cfg_ready, 0);
    send(5'b10001, 5, 5'b00000, 0);
    idle();
    check("t3_count_frozen", match_count, 2);
    apply(0, 0, 0, 1, 0, 0);
    idle();
    check("t3_clr_irq", irq, 0);
    check("t3_clr_cfg_ready", cfg_ready, 1);
    check("t3_clr_count", match_count, 2);

    // 4: din_valid low on alternate cycles
    cfg_start(5'b10001, 1, 3);
    send(5'b10001, 5, 5'b00001, 1);
    idle();
    check("t4_count", match_count, 1);

    // 5: stop together with completing bit, then irq_clr beats start
    apply(0, 0, 1, 0, 0, 0);
    cfg_start(5'b10001, 1, 3);
    send(4'b1000, 4, 4'b0000, 0);
    apply(0, 0, 1, 0, 1, 1);
    idle();
    check("t5_match", match, 0);
    check("t5_count", match_count, 0);
    check("t5_busy", busy, 0);
    check("t5_cfg_ready", cfg_ready, 1);
    cfg_start(5'b10001, 1, 1);
    send(5'b10001, 5, 5'b00001, 0);
    idle();
    check("t5_irq", irq, 1);
    apply(0, 1, 0, 1, 0, 0);
    idle();
    check("t5_clr_cfg_ready", cfg_ready, 1);
    check("t5_clr_busy", busy, 0);
    check("t5_clr_irq", irq, 0);

    // 6a: threshold 0 behaves as 1
    cfg_start(5'b10001, 1, 0);
    send(5'b10001, 5, 5'b00001, 0);
    idle();
    check("t6a_irq", irq, 1);
    check("t6a_count", match_count, 1);
    apply(0, 0, 0, 1, 0, 0);

    // 6b: five overlapping matches available, DONE at the third
    cfg_start(5'b10001, 1, 3);
    send(32'b1_0001_0001_0001_0001_0001, 21, 32'h0001_1100, 0);
    idle();
    check("t6b_count", match_count, 3);
    check("t6b_count_w2", match_count2, 3);
    check("t6b_irq_w2", irq2, 1);
    apply(0, 0, 0, 1, 0, 0);

    // 6c: async reset while match is high, then cfg regs are back to zero
    cfg_start(5'b10001, 1, 3);
    send(5'b10001, 5, 5'b00001, 0);
    idle();
    #2 reset = 1'b0;
    #1;
    check("t6c_match", match, 0);
    check("t6c_count", match_count, 0);
    check("t6c_busy", busy, 0);
    check("t6c_irq", irq, 0);
    check("t6c_cfg_ready", cfg_ready, 1);
    @(negedge clk) reset = 1'b1;
    apply(0, 1, 0, 0, 0, 0);
    exp_count = 0;
    thr_eff = 1;
    send(5'b00000, 5, 5'b00001, 0);
    idle();
    check("t6c_zero_cfg_irq", irq, 1);
    apply(0, 0, 0, 1, 0, 0);
    idle();
    idle();

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
